// File: rtl/iob_mem_responder_pkg.sv
// Shared IOb interconnect constants and types for the memory responder.
// Holds the FSM state encoding, default request/response field widths,
// the wait-counter width, and the per-request context captured on accept.
package iob_mem_responder_pkg;

   // Default IOb native bundle field widths
   localparam int unsigned IOB_ADDR_W = 32;
   localparam int unsigned IOB_DATA_W = 32;

   // Wait counter sized for WAIT_STATES in 0..15
   localparam int unsigned WAIT_CNT_W = 4;

   // Responder FSM state encoding
   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Request attributes the response phase still needs once the bus moves on
   typedef struct packed {
      logic we;   // request was a write (nonzero strobes)
      logic oor;  // address outside the internal RAM
   } req_ctx_t;

endpackage

// File: rtl/iob_sp_ram_be.sv
// Single-port synchronous RAM with per-byte write enables.
// Ports: clk; en (access enable); we (byte write enables, zero = read);
//        addr (word address); wdata; rdata (read data, 1-cycle latency,
//        held until the next read).
// Contents and read register have no reset.
module iob_sp_ram_be #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [DATA_W/8-1:0]   we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte-masked write, or registered read when no strobe is set
   always_ff @(posedge clk) begin
      if (en) begin
         if (|we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native memory responder: accepts one request per transaction from a
// CPU-side initiator and returns a single-cycle ready pulse after
// WAIT_STATES extra cycles, backed by an internal byte-writable RAM.
// Ports: clk; rst (async, active-low); valid/address/wdata/wstrb (request,
//        wstrb==0 is a read); ready (response pulse); rdata (read data,
//        held between reads).
// Optional: define IOB_MEM_RESPONDER_ERR_EN to add output 'error', pulsed
//        with ready for accesses outside the RAM.
module iob_mem_responder
   import iob_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = IOB_ADDR_W,
   parameter int unsigned DATA_W      = IOB_DATA_W,
   parameter int unsigned MEM_ADDR_W  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic                  ready,
   output logic [DATA_W-1:0]     rdata
`ifdef IOB_MEM_RESPONDER_ERR_EN
   ,
   output logic                  error
`endif
);

   localparam int unsigned STRB_W = DATA_W / 8;

   state_t                 state_q, state_d;
   logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
   req_ctx_t               ctx_q, ctx_d;
   logic                   ready_q;
   logic [DATA_W-1:0]      rdata_q, rdata_c;
   logic [DATA_W-1:0]      ram_rdata;
   logic                   accept_c, oor_c, ram_en_c;
   logic [STRB_W-1:0]      ram_we_c;
   logic                   unused_addr_lsb;

   // Byte offset within a word carries no meaning here
   assign unused_addr_lsb = ^address[1:0];

   // Any address bit above the RAM word index marks the access out of range
   assign oor_c    = |address[ADDR_W-1:MEM_ADDR_W+2];
   assign accept_c = (state_q == ST_IDLE) && valid;
   assign ram_en_c = accept_c && !oor_c;
   assign ram_we_c = ram_en_c ? wstrb : '0;

   // Writes commit and reads launch in the accept cycle
   iob_sp_ram_be #(
      .ADDR_W (MEM_ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en_c),
      .we    (ram_we_c),
      .addr  (address[MEM_ADDR_W+1:2]),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

   // Next-state, wait-count and request-context logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctx_d   = ctx_q;
      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               ctx_d.we  = |wstrb;
               ctx_d.oor = oor_c;
               if (WAIT_STATES != 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The RAM read register already holds the word in the response cycle,
   // so it feeds rdata directly there; otherwise rdata_q holds the last value.
   always_comb begin
      rdata_c = rdata_q;
      if (state_q == ST_RESP && !ctx_q.we) begin
         rdata_c = ctx_q.oor ? '0 : ram_rdata;
      end
   end

   // State and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ctx_q   <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctx_q   <= ctx_d;
         ready_q <= (state_d == ST_RESP);
         rdata_q <= rdata_c;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_c;

`ifdef IOB_MEM_RESPONDER_ERR_EN
   logic error_q;

   // Error flag rides alongside ready for out-of-range accesses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) error_q <= 1'b0;
      else      error_q <= (state_d == ST_RESP) && ctx_d.oor;
   end

   assign error = error_q;
`endif

endmodule
